// File: rtl/resp_uart_tx.sv
// resp_uart_tx: response byte FIFO feeding an LSB-first UART transmitter.
// Define RESP_UART_TX_PARITY_EN to add an even-parity bit (8E1 framing).
module resp_uart_tx #(
   parameter int CLK_FREQ_HZ = 100000000,
   parameter int BAUD_RATE   = 115200,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] cmd_resp_wr_data,
   input  logic       cmd_resp_wr_en,
   output logic       cmd_resp_full,
   output logic       uart_tx,
   output logic       tx_busy,
   output logic       overflow
);

   localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

`ifdef RESP_UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic [AW:0]   count;
   logic [AW:0]   count_nx;
   logic          push;
   logic          pop;
   logic          bit_end;
   logic [7:0]    head;
   state_t        state;
   logic [BW-1:0] baud;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
`ifdef RESP_UART_TX_PARITY_EN
   logic          par;
`endif

   // A full FIFO drops the write even if a pop frees a slot this cycle.
   assign push    = cmd_resp_wr_en && !cmd_resp_full;
   assign head    = mem[rd_ptr[AW-1:0]];
   assign bit_end = (baud == BAUD_LAST);
   assign pop     = (count != '0) &&
                    ((state == IDLE) || (state == STOP && bit_end));

   // Next occupancy; push and pop together leave it unchanged.
   always_comb begin
      count_nx = count;
      if (push && !pop)
         count_nx = count + 1'b1;
      else if (!push && pop)
         count_nx = count - 1'b1;
   end

   // Storage array; contents are don't-care once pointers reset.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr[AW-1:0]] <= cmd_resp_wr_data;
   end

   // FIFO pointers, occupancy, full flag and sticky overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         cmd_resp_full <= 1'b0;
         overflow      <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count         <= count_nx;
         cmd_resp_full <= (count_nx == DEPTH);
         if (cmd_resp_wr_en && cmd_resp_full)
            overflow <= 1'b1;
      end
   end

   // Frame sequencer with registered line and busy outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         baud    <= '0;
         bit_idx <= '0;
         shift   <= '0;
`ifdef RESP_UART_TX_PARITY_EN
         par     <= 1'b0;
`endif
         uart_tx <= 1'b1;
         tx_busy <= 1'b0;
      end else begin
         tx_busy <= (state != IDLE) || (count != '0);
         if (state == START)
            uart_tx <= 1'b0;
         else if (state == DATA)
            uart_tx <= shift[0];
`ifdef RESP_UART_TX_PARITY_EN
         else if (state == PARITY)
            uart_tx <= par;
`endif
         else
            uart_tx <= 1'b1;

         case (state)
            IDLE: begin
               baud <= '0;
               if (pop) begin
                  shift <= head;
`ifdef RESP_UART_TX_PARITY_EN
                  par   <= ^head;
`endif
                  state <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  baud    <= '0;
                  bit_idx <= '0;
                  state   <= DATA;
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  baud    <= '0;
                  shift   <= shift >> 1;
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7)
`ifdef RESP_UART_TX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
               end else begin
                  baud <= baud + 1'b1;
               end
            end
`ifdef RESP_UART_TX_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  baud  <= '0;
                  state <= STOP;
               end else begin
                  baud <= baud + 1'b1;
               end
            end
`endif
            STOP: begin
               if (bit_end) begin
                  baud <= '0;
                  if (pop) begin
                     shift <= head;
`ifdef RESP_UART_TX_PARITY_EN
                     par   <= ^head;
`endif
                     state <= START;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
